// File: rtl/slave_port_arbiter.sv
// ---------------------------------------------------------------------------
// slave_port_arbiter
//
// Two-master arbiter in front of the single 256x8 memory slave port. Whole
// transactions (one read burst or one write burst) are serialised onto the
// slave. Round-robin between the masters, with the grant locked until the
// transaction completes. Only one transaction is ever open on the slave.
//
// Packed channels (payloads pass through untouched):
//   read address  {addr[15:8], len[7:4], id[3:0]}   16 bits per master
//   write address {addr[11:4], id[3:0]}             12 bits per master
//   read data     {data[8:1], err[0]}               9 bits per master
//   write resp    {resp[4], id[3:0]}                5 bits per master
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   m_ar*/m_r*         per-master read channels (bit / slice i = master i)
//   m_aw*/m_w*/m_b*    per-master write channels
//   s_*                single slave port (requests out, responses in)
//   busy               high while a transaction is granted
//   owner              index of the granted master (valid when busy)
//   timeout_err        one-cycle pulse on a forced release
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : a granted transaction open for TIMEOUT_CYCLES cycles is
//               forcibly released and timeout_err pulses for one cycle.
//   Undefined : no watchdog, timeout_err is tied 0.
// ---------------------------------------------------------------------------
module slave_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  // master read channels
  input  logic [1:0]  m_arvalid,
  input  logic [31:0] m_arin,
  output logic [1:0]  m_arready,
  input  logic [1:0]  m_rready,
  output logic [1:0]  m_rvalid,
  output logic [1:0]  m_rlast,
  output logic [17:0] m_rdata,
  // master write channels
  input  logic [1:0]  m_awvalid,
  input  logic [23:0] m_awin,
  output logic [1:0]  m_awready,
  input  logic [1:0]  m_wvalid,
  input  logic [1:0]  m_wlast,
  input  logic [15:0] m_wdata,
  output logic [1:0]  m_wready,
  input  logic [1:0]  m_bready,
  output logic [1:0]  m_bvalid,
  output logic [9:0]  m_bresp,
  // slave port
  output logic        s_arvalid,
  output logic [15:0] s_arin,
  input  logic        s_arready,
  output logic        s_rready,
  input  logic        s_rvalid,
  input  logic        s_rlast,
  input  logic [8:0]  s_rdata,
  output logic        s_awvalid,
  output logic [11:0] s_awin,
  input  logic        s_awready,
  output logic        s_wvalid,
  output logic        s_wlast,
  output logic [7:0]  s_wdata,
  input  logic        s_wready,
  output logic        s_bready,
  input  logic        s_bvalid,
  input  logic [4:0]  s_bresp,
  // status
  output logic        busy,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t state_reg;
  logic   owner_reg;
  logic   last_owner_reg;

  logic [1:0] req;
  logic       grant_valid;
  logic       winner;
  logic       rd_act;
  logic       wr_act;
  logic       rd_done;
  logic       wr_done;

  assign req         = m_arvalid | m_awvalid;
  assign grant_valid = |req;
  assign rd_act      = (state_reg == RD);
  assign wr_act      = (state_reg == WR);

  // Completion is judged on the forwarded handshake, so s_rready/s_bready
  // already carry the owner's ready qualified by the current state.
  assign rd_done = s_rvalid & s_rlast & s_rready;
  assign wr_done = s_bvalid & s_bready;

  // A lone requester wins outright; on contention the master that did not
  // win last time gets the grant.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner_reg;
      default: winner = 1'b0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      cnt_reg        <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            owner_reg      <= winner;
            last_owner_reg <= winner;
            cnt_reg        <= '0;
            // Write wins over read inside one master.
            state_reg      <= m_awvalid[winner] ? WR : RD;
          end
        end
        RD, WR: begin
          if ((rd_act && rd_done) || (wr_act && wr_done)) begin
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            // Forced release; last_owner still names the stalled master,
            // so the other master has priority at the next arbitration.
            state_reg   <= IDLE;
            timeout_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign timeout_err = timeout_reg;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            owner_reg      <= winner;
            last_owner_reg <= winner;
            // Write wins over read inside one master.
            state_reg      <= m_awvalid[winner] ? WR : RD;
          end
        end
        RD:      if (rd_done) state_reg <= IDLE;
        WR:      if (wr_done) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign timeout_err = 1'b0;
`endif

  assign busy  = (state_reg != IDLE);
  assign owner = owner_reg;

  // Slave-side requests: owner's channels of the active direction only.
  always_comb begin
    s_arvalid = 1'b0;
    s_arin    = '0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_awin    = '0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_wdata   = '0;
    s_bready  = 1'b0;
    if (rd_act) begin
      s_arvalid = m_arvalid[owner_reg];
      s_arin    = owner_reg ? m_arin[31:16] : m_arin[15:0];
      s_rready  = m_rready[owner_reg];
    end
    if (wr_act) begin
      s_awvalid = m_awvalid[owner_reg];
      s_awin    = owner_reg ? m_awin[23:12] : m_awin[11:0];
      s_wvalid  = m_wvalid[owner_reg];
      s_wlast   = m_wlast[owner_reg];
      s_wdata   = owner_reg ? m_wdata[15:8] : m_wdata[7:0];
      s_bready  = m_bready[owner_reg];
    end
  end

  // Master-side responses: only the owner sees the slave, everyone else 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic rd_sel;
    logic wr_sel;

    assign rd_sel = rd_act & (owner_reg == 1'(gi));
    assign wr_sel = wr_act & (owner_reg == 1'(gi));

    assign m_arready[gi]      = rd_sel & s_arready;
    assign m_rvalid[gi]       = rd_sel & s_rvalid;
    assign m_rlast[gi]        = rd_sel & s_rlast;
    assign m_rdata[9*gi +: 9] = rd_sel ? s_rdata : 9'd0;

    assign m_awready[gi]      = wr_sel & s_awready;
    assign m_wready[gi]       = wr_sel & s_wready;
    assign m_bvalid[gi]       = wr_sel & s_bvalid;
    assign m_bresp[5*gi +: 5] = wr_sel ? s_bresp : 5'd0;
  end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_slave_port_arbiter
//
// Directed bench for slave_port_arbiter. The bench plays both masters and
// the slave. Inputs change just after the falling edge, outputs are checked
// on the falling edge (or 1 ns after an input change for combinational
// paths), so nothing is sampled at the active edge.
// ---------------------------------------------------------------------------
module tb_slave_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_arvalid = '0;
  logic [31:0] m_arin = '0;
  logic [1:0]  m_arready;
  logic [1:0]  m_rready = '0;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_rlast;
  logic [17:0] m_rdata;
  logic [1:0]  m_awvalid = '0;
  logic [23:0] m_awin = '0;
  logic [1:0]  m_awready;
  logic [1:0]  m_wvalid = '0;
  logic [1:0]  m_wlast = '0;
  logic [15:0] m_wdata = '0;
  logic [1:0]  m_wready;
  logic [1:0]  m_bready = '0;
  logic [1:0]  m_bvalid;
  logic [9:0]  m_bresp;
  logic        s_arvalid;
  logic [15:0] s_arin;
  logic        s_arready = 1'b0;
  logic        s_rready;
  logic        s_rvalid = 1'b0;
  logic        s_rlast = 1'b0;
  logic [8:0]  s_rdata = '0;
  logic        s_awvalid;
  logic [11:0] s_awin;
  logic        s_awready = 1'b0;
  logic        s_wvalid;
  logic        s_wlast;
  logic [7:0]  s_wdata;
  logic        s_wready = 1'b0;
  logic        s_bready;
  logic        s_bvalid = 1'b0;
  logic [4:0]  s_bresp = '0;
  logic        busy;
  logic        owner;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  slave_port_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arin(m_arin), .m_arready(m_arready),
    .m_rready(m_rready), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .m_awvalid(m_awvalid), .m_awin(m_awin), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wready(m_wready),
    .m_bready(m_bready), .m_bvalid(m_bvalid), .m_bresp(m_bresp),
    .s_arvalid(s_arvalid), .s_arin(s_arin), .s_arready(s_arready),
    .s_rready(s_rready), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rdata(s_rdata),
    .s_awvalid(s_awvalid), .s_awin(s_awin), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wdata(s_wdata), .s_wready(s_wready),
    .s_bready(s_bready), .s_bvalid(s_bvalid), .s_bresp(s_bresp),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  // Every DUT output in one vector (85 bits), and everything aimed at M1.
  logic [84:0] all_out;
  logic [19:0] m1_out;
  assign all_out = {m_arready, m_rvalid, m_rlast, m_rdata,
                    m_awready, m_wready, m_bvalid, m_bresp,
                    s_arvalid, s_arin, s_rready,
                    s_awvalid, s_awin, s_wvalid, s_wlast, s_wdata, s_bready,
                    busy, owner, timeout_err};
  assign m1_out = {m_arready[1], m_rvalid[1], m_rlast[1], m_rdata[17:9],
                   m_awready[1], m_wready[1], m_bvalid[1], m_bresp[9:5]};

  task automatic clear_inputs();
    m_arvalid = '0; m_arin = '0; m_rready = '0;
    m_awvalid = '0; m_awin = '0; m_wvalid = '0; m_wlast = '0; m_wdata = '0;
    m_bready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded wait (on falling edges) for a grant to appear.
  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_arvalid = 2'b11;
    m_awvalid = 2'b10;
    s_rvalid = 1'b1;
    s_bvalid = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_out !== 85'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    $display("reset: outputs=%h", all_out);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_m0_read();
    logic [8:0] beat;
    m_arvalid = 2'b01;
    m_arin[15:0] = 16'h0231;
    m_rready = 2'b01;
    @(negedge clk);
    total++;
    if ({busy, owner, s_arvalid, s_arin} !== {1'b1, 1'b0, 1'b1, 16'h0231}) begin
      bad++;
      $display("FAIL m0_grant: busy=%b owner=%b s_arvalid=%b s_arin=%h want 1 0 1 0231",
               busy, owner, s_arvalid, s_arin);
    end
    s_arready = 1'b1;
    #1;
    total++;
    if (m_arready !== 2'b01) begin
      bad++;
      $display("FAIL m0_arready: got %b want 01", m_arready);
    end
    @(negedge clk);
    m_arvalid = 2'b00;
    s_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      beat = {8'hA0 + 8'(b), (b == 1)};
      s_rvalid = 1'b1;
      s_rlast = (b == 2);
      s_rdata = beat;
      #1;
      total++;
      if ({m_rvalid, m_rlast, m_rdata, s_rready} !==
          {2'b01, ((b == 2) ? 2'b01 : 2'b00), 9'd0, beat, 1'b1}) begin
        bad++;
        $display("FAIL m0_beat%0d: rvalid=%b rlast=%b rdata=%h s_rready=%b want 01 %b %h 1",
                 b, m_rvalid, m_rlast, m_rdata, s_rready, (b == 2) ? 2'b01 : 2'b00, {9'd0, beat});
      end
      total++;
      if (m1_out !== 20'd0) begin
        bad++;
        $display("FAIL m1_quiet_beat%0d: got %h want 0", b, m1_out);
      end
      $display("m0_read beat %0d: rdata=%h rlast=%b", b, m_rdata, m_rlast);
      @(negedge clk);
    end
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL m0_read_release: busy=%b want 0", busy);
    end
  endtask

  task automatic test_mixed();
    do_reset();
    m_arvalid = 2'b01;
    m_arin[15:0] = 16'h1100;
    m_rready = 2'b01;
    m_awvalid = 2'b10;
    m_awin[23:12] = 12'h015;
    m_bready = 2'b10;
    @(negedge clk);
    total++;
    if ({busy, owner, s_arvalid, s_awvalid, m_awready} !== {1'b1, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL mixed_first: busy=%b owner=%b s_arvalid=%b s_awvalid=%b want 1 0 1 0",
               busy, owner, s_arvalid, s_awvalid);
    end
    // single-beat read completes at the next edge
    s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 9'h1FF;
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    m_arvalid = 2'b00;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mixed_idle_gap: busy=%b want 0", busy);
    end
    @(negedge clk);
    total++;
    if ({busy, owner, s_awvalid, s_awin, s_arvalid} !== {1'b1, 1'b1, 1'b1, 12'h015, 1'b0}) begin
      bad++;
      $display("FAIL mixed_m1_grant: busy=%b owner=%b s_awvalid=%b s_awin=%h s_arvalid=%b want 1 1 1 015 0",
               busy, owner, s_awvalid, s_awin, s_arvalid);
    end
    s_awready = 1'b1;
    m_wvalid = 2'b10; m_wlast = 2'b10; m_wdata[15:8] = 8'h5A;
    s_wready = 1'b1;
    #1;
    total++;
    if ({m_awready, m_wready, s_wvalid, s_wlast, s_wdata} !== {2'b10, 2'b10, 1'b1, 1'b1, 8'h5A}) begin
      bad++;
      $display("FAIL mixed_wdata: awready=%b wready=%b s_wvalid=%b s_wlast=%b s_wdata=%h want 10 10 1 1 5a",
               m_awready, m_wready, s_wvalid, s_wlast, s_wdata);
    end
    @(negedge clk);
    s_awready = 1'b0; s_wready = 1'b0;
    m_awvalid = 2'b00; m_wvalid = 2'b00; m_wlast = 2'b00;
    s_bvalid = 1'b1; s_bresp = 5'h15;
    #1;
    total++;
    if ({m_bvalid, m_bresp, s_bready} !== {2'b10, 5'h15, 5'h00, 1'b1}) begin
      bad++;
      $display("FAIL mixed_bresp: bvalid=%b bresp=%h s_bready=%b want 10 2a0 1",
               m_bvalid, m_bresp, s_bready);
    end
    $display("mixed: m1 write bresp=%h", m_bresp);
    @(negedge clk);
    s_bvalid = 1'b0; s_bresp = '0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mixed_wr_release: busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic exp_owner;
    do_reset();
    m_arvalid = 2'b11;
    m_arin = 32'hBEEF_CAFE;
    m_rready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_owner = 1'(t % 2);
      wait_busy(ok);
      total++;
      if (!ok || owner !== exp_owner) begin
        bad++;
        $display("FAIL rr_owner%0d: busy=%b owner=%b want 1 %b", t, busy, owner, exp_owner);
      end
      $display("round_robin txn %0d: owner=%b", t, owner);
      s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
      @(negedge clk);
      s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_write_priority();
    bit ok;
    do_reset();
    m_arvalid = 2'b10;
    m_awvalid = 2'b10;
    m_rready = 2'b10;
    m_bready = 2'b10;
    wait_busy(ok);
    total++;
    if (!ok || {owner, s_awvalid, s_arvalid} !== 3'b110) begin
      bad++;
      $display("FAIL wpri_first: busy=%b owner=%b s_awvalid=%b s_arvalid=%b want 1 1 1 0",
               busy, owner, s_awvalid, s_arvalid);
    end
    s_bvalid = 1'b1;
    @(negedge clk);
    s_bvalid = 1'b0;
    m_awvalid = 2'b00;
    wait_busy(ok);
    total++;
    if (!ok || {owner, s_awvalid, s_arvalid} !== 3'b101) begin
      bad++;
      $display("FAIL wpri_second: busy=%b owner=%b s_awvalid=%b s_arvalid=%b want 1 1 0 1",
               busy, owner, s_awvalid, s_arvalid);
    end
    $display("write_priority: second grant s_arvalid=%b", s_arvalid);
    s_rvalid = 1'b1; s_rlast = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset();
    m_arvalid = 2'b11;
    m_rready = 2'b11;
    wait_busy(ok);
    total++;
    if (!ok || owner !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_grant: busy=%b owner=%b want 1 0", busy, owner);
    end
    s_rvalid = 1'b1; s_rdata = 9'h011;
    @(negedge clk);
    s_rdata = 9'h022;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (all_out !== 85'd0) begin
      bad++;
      $display("FAIL rstmid_outputs: got %h want 0", all_out);
    end
    m_arvalid = 2'b10;
    s_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_busy(ok);
    total++;
    if (!ok || owner !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_m1_first: busy=%b owner=%b want 1 1", busy, owner);
    end
    $display("reset_mid_burst: after release owner=%b", owner);
    s_rvalid = 1'b1; s_rlast = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n;
    do_reset();
    m_arvalid = 2'b11;
    m_rready = 2'b11;
    s_rvalid = 1'b1;
    wait_busy(ok);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (!ok || n != 16 || owner !== 1'b0) begin
      bad++;
      $display("FAIL timeout_cycles: busy_cycles=%0d owner=%b want 16 0", n, owner);
    end
    total++;
    if ({busy, timeout_err} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_pulse: busy=%b timeout_err=%b want 0 1", busy, timeout_err);
    end
    @(negedge clk);
    total++;
    if ({busy, owner, timeout_err} !== 3'b110) begin
      bad++;
      $display("FAIL timeout_next: busy=%b owner=%b timeout_err=%b want 1 1 0",
               busy, owner, timeout_err);
    end
    $display("timeout: released after %0d cycles, next owner=%b", n, owner);
    do_reset();
  endtask
`else
  task automatic test_timeout();
    bit ok;
    bit held;
    do_reset();
    m_arvalid = 2'b01;
    m_rready = 2'b01;
    s_rvalid = 1'b1;
    wait_busy(ok);
    held = ok;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || timeout_err !== 1'b0) held = 1'b0;
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL no_timeout_hold: busy=%b timeout_err=%b want 1 0", busy, timeout_err);
    end
    $display("no_timeout: grant held for 40 cycles busy=%b", busy);
    s_rlast = 1'b1;
    @(negedge clk);
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_m0_read();
    test_mixed();
    test_round_robin();
    test_write_priority();
    test_reset_mid_burst();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slave_port_arbiter.md
Name: slave_port_arbiter

Overview:
Two-master arbiter in front of the single 256x8 memory slave port. It serialises whole transactions (read burst or write burst) from master 0 and master 1 onto the one slave. Channels are packed: read address {addr[15:8], len[7:4], id[3:0]}, write address {addr[11:4], id[3:0]}, read data {data[8:1], err[0]}, and write response {resp[4], id[3:0]}. Arbitration is round-robin with grant locked for a full transaction. Only one transaction is outstanding on the slave at any time.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles a granted transaction may stay open (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
m_arvalid  in  2  per-master read address valid, bit i = master i
m_arin  in  32  per-master packed read address, [16i+15:16i]
m_arready  out  2  per-master read address ready
m_rready  in  2  per-master read data ready
m_rvalid  out  2  per-master read data valid
m_rlast  out  2  per-master last read beat
m_rdata  out  18  per-master {data,err}, [9i+8:9i]
m_awvalid  in  2  per-master write address valid
m_awin  in  24  per-master packed write address, [12i+11:12i]
m_awready  out  2  per-master write address ready
m_wvalid  in  2  per-master write data valid
m_wlast  in  2  per-master last write beat
m_wdata  in  16  per-master write data, [8i+7:8i]
m_wready  out  2  per-master write data ready
m_bready  in  2  per-master response ready
m_bvalid  out  2  per-master response valid
m_bresp  out  10  per-master {resp,id}, [5i+4:5i]
s_arvalid, s_arin[16], s_rready, s_awvalid, s_awin[12], s_wvalid, s_wlast, s_wdata[8], s_bready  out  slave-side requests
s_arready, s_rvalid, s_rlast, s_rdata[9], s_awready, s_wready, s_bvalid, s_bresp[5]  in  slave-side responses
busy  out  1  high while state != IDLE
owner  out  1  index of granted master; valid when busy
timeout_err  out  1  one-cycle pulse on forced release (0 when feature is compiled out)

Behaviour:
- Registered state: IDLE, RD, WR. Also a registered owner and a registered last_owner.
- Reset (async): state=IDLE, owner=0, last_owner=1. All outputs are 0 immediately, because outputs are decoded from registered state only.
- Request of master i: req[i] = m_arvalid[i] | m_awvalid[i].
- IDLE, on clock edge:
  - if only one master requests, grant it;
  - if both request, grant ~last_owner.
  - For the granted master: m_awvalid set -> WR, else -> RD. Write wins over read inside one master.
  - On grant, owner and last_owner both load the winner.
- Grant latency: a request sampled in IDLE at edge N is forwarded from cycle N+1.
- RD forwarding (combinational, owner only):
  - master -> slave: s_arvalid, s_arin, s_rready.
  - slave -> master: m_arready, m_rvalid, m_rlast, m_rdata.
- WR forwarding (combinational, owner only):
  - master -> slave: s_awvalid, s_awin, s_wvalid, s_wlast, s_wdata, s_bready.
  - slave -> master: m_awready, m_wready, m_bvalid, m_bresp.
- Channels not belonging to the current state, all slave-side outputs in IDLE, and all outputs toward the non-owner are driven 0.
- RD -> IDLE when s_rvalid & s_rlast & s_rready are sampled high at an edge.
- WR -> IDLE when s_bvalid & s_bready are sampled high at an edge.
- IDLE always lasts at least one cycle. The next grant therefore occurs at earliest 2 edges after the completing handshake.
- Non-owner requests are ignored mid-transaction. The non-owner's valid stays held and is served at the next arbitration.
- With both masters continuously requesting, grants strictly alternate 0,1,0,1.
- Payloads pass through untouched. The arbiter does not interpret len, addr, or err.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A cycle counter clears on entry to RD/WR and increments each cycle in RD/WR.
  - When it reaches TIMEOUT_CYCLES-1 without completion, state -> IDLE and timeout_err pulses high for exactly 1 cycle (the first IDLE cycle).
  - last_owner keeps the timed-out master, so the other master gets priority next.
- Undefined: no counter; timeout_err tied 0; a hung slave holds the grant forever.

Test Plan:
- Reset, then M0 read with m_arin[15:0]=16'h0231 -> busy=1, owner=0 next cycle, s_arin=16'h0231, 3 beats forwarded to M0 only, IDLE one edge after the rlast handshake; M1 outputs 0 throughout.
- Same-cycle M0 read and M1 write (awin=12'h015) after reset -> M0 granted first; M1 WR granted 2 edges after M0's rlast handshake, s_awin=12'h015, m_bresp[9:5] equals s_bresp.
- Both masters requesting reads continuously for 4 transactions -> owner sequence 0,1,0,1.
- M1 asserts arvalid and awvalid together -> WR granted first, RD on the following arbitration.
- Assert rst during beat 2 of a read burst -> all outputs 0 in the same cycle, busy=0; after release, a pending M1 request is granted first.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts rlast -> return to IDLE after 16 cycles in RD, timeout_err high for 1 cycle, waiting master granted next.
